tc_pl_cap_sched: RTL and testbench

Capture scheduler for the PL capture controller: decides when a multi-gain capture starts and supervises its completion. It issues the one-cycle `cap_trig` from a software, external or periodic source and counts captures per burst. It runs a completion watchdog that resets a hung capture controller and reports errors. It sits between the PS register bank and the capture controller, all on `clk125`.

---
 rtl/tc_pl_cap_sched.sv | 187 ++++++++++++++++++
 tb/tb_tc_pl_cap_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_pl_cap_sched.sv
// Capture scheduler: issues cap_trig from software, external-edge or periodic
// sources, counts captures per burst and supervises completion with a watchdog.
module tc_pl_cap_sched #(
  parameter int CNT_W = 32,
  parameter int BST_W = 16
) (
  input  logic             clk125,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             sw_trig,
  input  logic             ext_trig,
  input  logic [CNT_W-1:0] period,
  input  logic [BST_W-1:0] burst_num,
  input  logic [CNT_W-1:0] timeout,
  input  logic             err_clr,
  input  logic             cap_cmpt,
  output logic             cap_trig,
  output logic             cap_rst,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic             overrun,
  output logic [BST_W-1:0] cap_count
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_GAP} state_t;

  localparam logic [1:0]       MODE_SW   = 2'd0;
  localparam logic [1:0]       MODE_EXT  = 2'd1;
  localparam logic [1:0]       MODE_PER  = 2'd2;
  localparam logic [1:0]       MODE_RSV  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
  localparam logic [BST_W-1:0] BST_ZERO  = '0;
  localparam logic [BST_W-1:0] BST_ONE   = BST_W'(1);

  state_t           state, state_nx;
  logic [1:0]       mode_s;
  logic [CNT_W-1:0] period_s, timeout_s;
  logic [BST_W-1:0] burst_s;
  logic [CNT_W-1:0] per_cnt, wd_cnt;
  logic             per_run, pending, ext_q;

  logic             tick, trig_hit, wd_exp, start, ovr_set, to_set;
  logic             cap_trig_d, cap_rst_d, done_d;
  logic [BST_W-1:0] count_inc;

  assign busy      = (state != S_IDLE);
  assign tick      = (mode_s == MODE_PER) && per_run && (per_cnt == period_s - CNT_ONE);
  assign wd_exp    = (timeout_s != CNT_ZERO) && (wd_cnt == timeout_s);
  assign count_inc = (&cap_count) ? cap_count : cap_count + BST_ONE;
  assign ovr_set   = tick && ((state == S_WAIT) || (state == S_GAP));

  // Trigger qualification; the first periodic trigger of a burst does not wait for a tick.
  always_comb begin
    trig_hit = 1'b0;
    case (mode_s)
      MODE_SW:  trig_hit = sw_trig;
      MODE_EXT: trig_hit = ext_trig && !ext_q;
      MODE_PER: trig_hit = tick || pending || !per_run;
      default:  trig_hit = 1'b0;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_nx   = state;
    start      = 1'b0;
    cap_trig_d = 1'b0;
    cap_rst_d  = 1'b0;
    done_d     = 1'b0;
    to_set     = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && (mode != MODE_RSV)) begin
          state_nx = S_ARM;
          start    = 1'b1;
        end
      end
      S_ARM: begin
        if (!enable) begin
          state_nx = S_IDLE;
          done_d   = 1'b1;
        end else if (trig_hit) begin
          state_nx   = S_WAIT;
          cap_trig_d = 1'b1;
        end
      end
      S_WAIT: begin
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (cap_cmpt) begin
          if (((burst_s != BST_ZERO) && (count_inc == burst_s)) || !enable) begin
            state_nx = S_IDLE;
            done_d   = 1'b1;
          end else begin
            state_nx = S_GAP;
          end
        end else if (wd_exp) begin
          state_nx  = S_IDLE;
          to_set    = 1'b1;
          cap_rst_d = 1'b1;
          done_d    = 1'b1;
        end
      end
      S_GAP:   state_nx = S_ARM;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk125) begin
    if (rst) begin
      state    <= S_IDLE;
      cap_trig <= 1'b0;
      cap_rst  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      cap_trig <= cap_trig_d;
      cap_rst  <= cap_rst_d;
      done     <= done_d;
    end
  end

  // NOTE: shadow configuration is reset too, so a burst never starts from unknown settings.
  always_ff @(posedge clk125) begin
    if (rst) begin
      mode_s      <= MODE_SW;
      period_s    <= CNT_TWO;
      burst_s     <= BST_ZERO;
      timeout_s   <= CNT_ZERO;
      cap_count   <= BST_ZERO;
      per_cnt     <= CNT_ZERO;
      per_run     <= 1'b0;
      pending     <= 1'b0;
      wd_cnt      <= CNT_ZERO;
      ext_q       <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      ext_q <= ext_trig;

      if (start) begin
        mode_s    <= mode;
        period_s  <= (period < CNT_TWO) ? CNT_TWO : period;
        burst_s   <= burst_num;
        timeout_s <= timeout;
        cap_count <= BST_ZERO;
        per_cnt   <= CNT_ZERO;
        per_run   <= 1'b0;
        pending   <= 1'b0;
      end else begin
        if ((state == S_WAIT) && cap_cmpt)
          cap_count <= count_inc;

        // Period timer free-runs from the first trigger of the burst.
        if (cap_trig_d && !per_run && (mode_s == MODE_PER)) begin
          per_run <= 1'b1;
          per_cnt <= CNT_ZERO;
        end else if (per_run) begin
          per_cnt <= tick ? CNT_ZERO : per_cnt + CNT_ONE;
        end

        if (cap_trig_d)
          pending <= 1'b0;
        else if (ovr_set)
          pending <= 1'b1;
      end

      wd_cnt <= (state == S_WAIT) ? wd_cnt + CNT_ONE : CNT_ZERO;

      // A new error in the same cycle as err_clr keeps the flag set.
      if (to_set)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;

      if (ovr_set)
        overrun <= 1'b1;
      else if (err_clr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tc_pl_cap_sched.sv
// Directed bench for tc_pl_cap_sched: burst, periodic, overrun, watchdog,
// external edge, disable and mid-capture reset scenarios.
module tb_tc_pl_cap_sched;

  localparam int CNT_W = 32;
  localparam int BST_W = 16;

  logic             clk125 = 1'b0;
  logic             rst;
  logic             enable;
  logic [1:0]       mode;
  logic             sw_trig;
  logic             ext_trig;
  logic [CNT_W-1:0] period;
  logic [BST_W-1:0] burst_num;
  logic [CNT_W-1:0] timeout;
  logic             err_clr;
  logic             cap_cmpt;
  logic             cap_trig;
  logic             cap_rst;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic             overrun;
  logic [BST_W-1:0] cap_count;

  int n_pass  = 0;
  int n_total = 0;
  int edge_n  = 0;
  int n_trig  = 0;
  int n_rst   = 0;
  int n_done  = 0;

  tc_pl_cap_sched #(.CNT_W(CNT_W), .BST_W(BST_W)) dut (
    .clk125      (clk125),
    .rst         (rst),
    .enable      (enable),
    .mode        (mode),
    .sw_trig     (sw_trig),
    .ext_trig    (ext_trig),
    .period      (period),
    .burst_num   (burst_num),
    .timeout     (timeout),
    .err_clr     (err_clr),
    .cap_cmpt    (cap_cmpt),
    .cap_trig    (cap_trig),
    .cap_rst     (cap_rst),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .overrun     (overrun),
    .cap_count   (cap_count)
  );

  always #4 clk125 = ~clk125;

  always @(posedge clk125) edge_n <= edge_n + 1;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk125) begin
    if (cap_trig === 1'b1) n_trig <= n_trig + 1;
    if (cap_rst === 1'b1)  n_rst  <= n_rst + 1;
    if (done === 1'b1)     n_done <= n_done + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk125);
    #1;
  endtask

  // Steps until cap_trig is seen; t is the edge that raised it.
  task automatic wait_trig(input string tag, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (cap_trig === 1'b1) begin
        t = edge_n;
        break;
      end
    end
    if (t < 0) check({tag, "_no_trig"}, {31'd0, cap_trig}, 32'd1);
  endtask

  // Holds cap_cmpt high during the cycle d cycles after the current one;
  // e is the edge that sampled it.
  task automatic do_cmpt(input int d, output int e);
    repeat (d) step();
    cap_cmpt = 1'b1;
    step();
    cap_cmpt = 1'b0;
    e = edge_n;
  endtask

  initial begin
    #200_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int t0, t, e, ntr0, nrst0, ndone0;

    rst = 1'b1; enable = 1'b0; mode = 2'd0; sw_trig = 1'b0; ext_trig = 1'b0;
    period = '0; burst_num = '0; timeout = '0; err_clr = 1'b0; cap_cmpt = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_outputs", {26'd0, cap_trig, cap_rst, busy, done, timeout_err, overrun}, 32'd0);
    check("reset_count", {16'd0, cap_count}, 32'd0);

    // Reserved mode keeps the scheduler idle.
    mode = 2'd3; enable = 1'b1;
    repeat (3) step();
    check("mode3_idle", {31'd0, busy}, 32'd0);
    enable = 1'b0;
    step();

    // Software burst of three.
    mode = 2'd0; burst_num = 16'd3; timeout = '0; enable = 1'b1;
    step();
    check("sw_busy_arm", {31'd0, busy}, 32'd1);
    ntr0 = n_trig; ndone0 = n_done;
    for (int k = 0; k < 3; k++) begin
      sw_trig = 1'b1;
      step();
      sw_trig = 1'b0;
      check("sw_trig_latency", {31'd0, cap_trig}, 32'd1);
      do_cmpt(10, e);
      if (k < 2) step();
    end
    check("sw_done", {31'd0, done}, 32'd1);
    check("sw_busy_low", {31'd0, busy}, 32'd0);
    check("sw_count", {16'd0, cap_count}, 32'd3);
    enable = 1'b0;
    step();
    check("sw_trig_pulses", n_trig - ntr0, 32'd3);
    check("sw_done_pulses", n_done - ndone0, 32'd1);

    // Periodic spacing, period 100, four captures of 20 cycles.
    mode = 2'd2; period = 32'd100; burst_num = 16'd4; enable = 1'b1;
    step();
    wait_trig("per_first", 5, t0);
    check("per_first_latency", t0 - edge_n + 1, 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        wait_trig("per_next", 200, t);
        check("per_spacing", t - t0, 100 * k);
      end
      do_cmpt(20, e);
    end
    check("per_done", {31'd0, done}, 32'd1);
    check("per_count", {16'd0, cap_count}, 32'd4);
    check("per_no_overrun", {31'd0, overrun}, 32'd0);
    enable = 1'b0;
    step();

    // Periodic overrun, period 50, captures of 70 cycles.
    period = 32'd50; burst_num = 16'd3; enable = 1'b1;
    step();
    wait_trig("ovr_first", 5, t);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        wait_trig("ovr_next", 10, t);
        check("ovr_retrig_gap", t - e, 32'd2);
      end
      do_cmpt(70, e);
    end
    check("ovr_done", {31'd0, done}, 32'd1);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    enable = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Watchdog expiry with no completion.
    mode = 2'd0; burst_num = 16'd0; timeout = 32'd1000; enable = 1'b1;
    step();
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    t0 = edge_n;
    t = -1;
    for (int i = 0; i < 1100; i++) begin
      step();
      if (cap_rst === 1'b1) begin
        t = edge_n;
        break;
      end
    end
    check("wd_rst_time", t - t0, 32'd1001);
    check("wd_done", {31'd0, done}, 32'd1);
    check("wd_err", {31'd0, timeout_err}, 32'd1);
    check("wd_count", {16'd0, cap_count}, 32'd0);
    check("wd_busy_low", {31'd0, busy}, 32'd0);
    enable = 1'b0;
    step();
    check("wd_rst_one_cycle", {31'd0, cap_rst}, 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("wd_err_cleared", {31'd0, timeout_err}, 32'd0);

    // Completion on the expiry cycle wins.
    burst_num = 16'd1; enable = 1'b1;
    step();
    nrst0 = n_rst;
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    do_cmpt(1000, e);
    check("wd_tie_done", {31'd0, done}, 32'd1);
    check("wd_tie_count", {16'd0, cap_count}, 32'd1);
    enable = 1'b0;
    repeat (3) step();
    check("wd_tie_no_err", {31'd0, timeout_err}, 32'd0);
    check("wd_tie_no_rst", n_rst - nrst0, 32'd0);

    // External edge, software pulses ignored.
    mode = 2'd1; burst_num = 16'd0; timeout = '0; enable = 1'b1;
    step();
    ntr0 = n_trig;
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    repeat (3) step();
    check("ext_sw_ignored", n_trig - ntr0, 32'd0);
    ext_trig = 1'b1;
    step();
    check("ext_trig_latency", {31'd0, cap_trig}, 32'd1);
    repeat (3) step();
    cap_cmpt = 1'b1;
    step();
    cap_cmpt = 1'b0;
    repeat (15) step();
    ext_trig = 1'b0;
    step();
    check("ext_single_trig", n_trig - ntr0, 32'd1);

    // Disable during WAIT is honoured at completion.
    ext_trig = 1'b1;
    step();
    check("dis_trig", {31'd0, cap_trig}, 32'd1);
    enable = 1'b0;
    repeat (5) step();
    check("dis_still_busy", {30'd0, busy, done}, 32'd2);
    cap_cmpt = 1'b1;
    step();
    cap_cmpt = 1'b0;
    ext_trig = 1'b0;
    check("dis_done", {30'd0, busy, done}, 32'd1);
    check("dis_count", {16'd0, cap_count}, 32'd2);

    // Reset mid-WAIT.
    mode = 2'd0; burst_num = 16'd0; timeout = 32'd20; enable = 1'b1;
    step();
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    repeat (3) step();
    ndone0 = n_done; nrst0 = n_rst;
    rst = 1'b1;
    step();
    check("rst_mid_outputs", {26'd0, cap_trig, cap_rst, busy, done, timeout_err, overrun}, 32'd0);
    check("rst_mid_count", {16'd0, cap_count}, 32'd0);
    enable = 1'b0;
    repeat (30) step();
    rst = 1'b0;
    repeat (3) step();
    check("rst_mid_no_pulses", (n_done - ndone0) + (n_rst - nrst0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
